// File: rtl/usb_link_dir_ctrl_if.sv
// usb_link_dir_ctrl_if: status inputs and direction/handshake outputs of the USB link direction controller
interface usb_link_dir_ctrl_if;
    logic       rxActive;
    logic       usbResetDetect;
    logic       txReq;
    logic       expectResponse;
    logic       txSending;
    logic       outEN;
    logic       txReqSendPacket;
    logic       txGrant;
    logic       respTimeout;
    logic [2:0] state;
    modport master (
        output rxActive, usbResetDetect, txReq, expectResponse, txSending,
        input  outEN, txReqSendPacket, txGrant, respTimeout, state
    );
    modport slave (
        input  rxActive, usbResetDetect, txReq, expectResponse, txSending,
        output outEN, txReqSendPacket, txGrant, respTimeout, state
    );
endinterface

// File: rtl/usb_link_dir_ctrl.sv
// usb_link_dir_ctrl: half-duplex bus direction FSM sequencing receive, inter-packet gap,
// transmit and host-response wait, with registered outputs.
module usb_link_dir_ctrl #(
    parameter int IPG_CYCLES          = 8,
    parameter int RESP_TIMEOUT_CYCLES = 72
) (
    input logic                clk48,
    input logic                RST,
    usb_link_dir_ctrl_if.slave bus
);
    localparam int MAXC = (IPG_CYCLES > RESP_TIMEOUT_CYCLES) ? IPG_CYCLES : RESP_TIMEOUT_CYCLES;
    localparam int W    = $clog2(MAXC + 1);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX        = 3'd1,
        GAP       = 3'd2,
        TX_START  = 3'd3,
        TX        = 3'd4,
        WAIT_RESP = 3'd5
    } st_t;
    // held as a raw vector so the unused encodings 6-7 are representable and recoverable
    logic [2:0]   st, st_n;
    logic [W-1:0] gap_cnt, gap_n, resp_cnt, resp_n;
    logic         exp_q, exp_n;
    logic         oe, send, grant, tmo;
    logic         send_n, grant_n, tmo_n;

    always_ff @(posedge clk48) begin
        if (RST) begin
            st       <= IDLE;
            gap_cnt  <= '0;
            resp_cnt <= '0;
            exp_q    <= 1'b0;
            oe       <= 1'b0;
            send     <= 1'b0;
            grant    <= 1'b0;
            tmo      <= 1'b0;
        end else begin
            st       <= st_n;
            gap_cnt  <= gap_n;
            resp_cnt <= resp_n;
            exp_q    <= exp_n;
            oe       <= st_n == TX_START || st_n == TX;
            send     <= send_n;
            grant    <= grant_n;
            tmo      <= tmo_n;
        end
    end

    always_comb begin
        st_n    = st;
        exp_n   = exp_q;
        send_n  = 1'b0;
        grant_n = 1'b0;
        tmo_n   = 1'b0;
        case (st)
            IDLE: begin
                if (bus.rxActive) st_n = RX;
                else if (bus.txReq) begin
                    st_n    = TX_START;
                    send_n  = 1'b1;
                    grant_n = 1'b1;
                    exp_n   = bus.expectResponse;
                end
            end
            RX:       st_n = bus.rxActive ? RX : GAP;
            GAP:      st_n = bus.rxActive ? RX : (gap_cnt == W'(IPG_CYCLES - 1)) ? IDLE : GAP;
            TX_START: st_n = bus.txSending ? TX : TX_START;
            TX:       st_n = bus.txSending ? TX : exp_q ? WAIT_RESP : GAP;
            WAIT_RESP: begin
                if (bus.rxActive) st_n = RX;
                else if (resp_cnt == W'(RESP_TIMEOUT_CYCLES - 1)) begin
                    st_n  = IDLE;
                    tmo_n = 1'b1;
                end
            end
            default:  st_n = IDLE;
        endcase
        // bus reset overrides every transition and any pulse decided above
        if (bus.usbResetDetect) begin
            st_n    = IDLE;
            exp_n   = 1'b0;
            send_n  = 1'b0;
            grant_n = 1'b0;
            tmo_n   = 1'b0;
        end
        gap_n  = (st == GAP && st_n == GAP) ? gap_cnt + W'(gap_cnt != '1) : '0;
        resp_n = (st == WAIT_RESP && st_n == WAIT_RESP) ? resp_cnt + W'(resp_cnt != '1) : '0;
    end

    assign bus.state           = st;
    assign bus.outEN           = oe;
    assign bus.txReqSendPacket = send;
    assign bus.txGrant         = grant;
    assign bus.respTimeout     = tmo;
endmodule

// File: tb/tb_usb_link_dir_ctrl.sv
// tb_usb_link_dir_ctrl: directed scoreboard bench for usb_link_dir_ctrl; expected
// {state,outEN,txReqSendPacket,txGrant,respTimeout} tuples are queued then checked after each edge.
module tb_usb_link_dir_ctrl;
    logic clk48 = 1'b0;
    logic RST   = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   to_cnt = 0;
    int   gr_cnt = 0;
    int   snap;

    typedef struct {
        string      tag;
        logic [6:0] v;
    } exp_t;
    exp_t sb[$];

    localparam logic [2:0] S_IDLE = 3'd0, S_RX = 3'd1, S_GAP = 3'd2, S_TXS = 3'd3, S_TX = 3'd4, S_WR = 3'd5;

    usb_link_dir_ctrl_if bus ();
    usb_link_dir_ctrl #(.IPG_CYCLES(8), .RESP_TIMEOUT_CYCLES(72)) dut (
        .clk48(clk48),
        .RST  (RST),
        .bus  (bus)
    );

    always #5 clk48 = ~clk48;

    always @(negedge clk48) begin
        if (bus.respTimeout) to_cnt++;
        if (bus.txGrant) gr_cnt++;
    end

    task automatic tick();
        @(posedge clk48);
        #1;
    endtask

    task automatic cmp();
        exp_t       e;
        logic [6:0] o;
        e = sb.pop_front();
        o = {bus.state, bus.outEN, bus.txReqSendPacket, bus.txGrant, bus.respTimeout};
        n_cmp++;
        assert (o === e.v) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", e.tag, o, e.v);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] s, input logic oe, input logic sn,
                        input logic gr, input logic to);
        exp_t e;
        e.tag = tag;
        e.v   = {s, oe, sn, gr, to};
        sb.push_back(e);
        tick();
        cmp();
    endtask

    task automatic chk_int(input string tag, input int got, input int want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // run a granted packet of len cycles with txSending, ending on the first post-TX edge
    task automatic send_pkt(input string tag, input logic er, input int len, input logic [2:0] after);
        bus.txReq = 1'b1;
        bus.expectResponse = er;
        step({tag, "_grant"}, S_TXS, 1, 1, 1, 0);
        bus.txReq = 1'b0;
        bus.expectResponse = 1'b0;
        bus.txSending = 1'b1;
        step({tag, "_tx"}, S_TX, 1, 0, 0, 0);
        repeat (len - 1) tick();
        bus.txSending = 1'b0;
        step({tag, "_end"}, after, 0, 0, 0, 0);
    endtask

    initial begin
        bus.rxActive = 1'b0;
        bus.usbResetDetect = 1'b0;
        bus.txReq = 1'b0;
        bus.expectResponse = 1'b0;
        bus.txSending = 1'b0;
        tick();
        step("reset", S_IDLE, 0, 0, 0, 0);
        RST = 1'b0;

        // plain packet: grant, hold-in TX_START, 40 cycles of TX, then 8-cycle gap
        bus.txReq = 1'b1;
        step("t1_grant", S_TXS, 1, 1, 1, 0);
        bus.txReq = 1'b0;
        step("t1_hold", S_TXS, 1, 0, 0, 0);
        bus.txSending = 1'b1;
        step("t1_tx", S_TX, 1, 0, 0, 0);
        repeat (39) tick();
        bus.txSending = 1'b0;
        step("t1_gap", S_GAP, 0, 0, 0, 0);
        snap = gr_cnt;
        bus.txReq = 1'b1;
        bus.expectResponse = 1'b1;
        repeat (6) tick();
        step("t1_gap_last", S_GAP, 0, 0, 0, 0);
        step("t1_idle", S_IDLE, 0, 0, 0, 0);
        chk_int("t1_gap_ignores_req", gr_cnt, snap);

        // request held through GAP is served on the first IDLE cycle; response expected -> timeout
        step("t2_grant", S_TXS, 1, 1, 1, 0);
        bus.txReq = 1'b0;
        bus.expectResponse = 1'b0;
        bus.txSending = 1'b1;
        step("t2_tx", S_TX, 1, 0, 0, 0);
        repeat (19) tick();
        bus.txSending = 1'b0;
        snap = to_cnt;
        step("t2_wait", S_WR, 0, 0, 0, 0);
        repeat (70) tick();
        step("t2_wait_71", S_WR, 0, 0, 0, 0);
        step("t2_timeout", S_IDLE, 0, 0, 0, 1);
        step("t2_pulse_once", S_IDLE, 0, 0, 0, 0);
        chk_int("t2_to_count", to_cnt, snap + 1);

        // response at WAIT_RESP cycle 30
        send_pkt("t3", 1'b1, 20, S_WR);
        snap = to_cnt;
        repeat (30) tick();
        bus.rxActive = 1'b1;
        step("t3_rx", S_RX, 0, 0, 0, 0);
        bus.rxActive = 1'b0;
        step("t3_gap", S_GAP, 0, 0, 0, 0);
        repeat (8) tick();
        chk_int("t3_no_timeout", to_cnt, snap);

        // response arriving on the expiry cycle: receive wins
        send_pkt("t4", 1'b1, 5, S_WR);
        repeat (71) tick();
        bus.rxActive = 1'b1;
        step("t4_rx_wins", S_RX, 0, 0, 0, 0);
        bus.rxActive = 1'b0;
        step("t4_gap", S_GAP, 0, 0, 0, 0);
        repeat (8) tick();
        chk_int("t4_no_timeout", to_cnt, snap);

        // simultaneous rxActive and txReq in IDLE
        snap = gr_cnt;
        bus.rxActive = 1'b1;
        bus.txReq = 1'b1;
        step("t5_rx", S_RX, 0, 0, 0, 0);
        bus.rxActive = 1'b0;
        step("t5_gap", S_GAP, 0, 0, 0, 0);
        repeat (6) tick();
        step("t5_gap_last", S_GAP, 0, 0, 0, 0);
        chk_int("t5_no_grant", gr_cnt, snap);
        step("t5_idle", S_IDLE, 0, 0, 0, 0);
        step("t5_grant", S_TXS, 1, 1, 1, 0);
        bus.txReq = 1'b0;

        // bus reset during TX, then a late txSending fall
        bus.txSending = 1'b1;
        step("t6_tx", S_TX, 1, 0, 0, 0);
        repeat (3) tick();
        bus.usbResetDetect = 1'b1;
        step("t6_busrst", S_IDLE, 0, 0, 0, 0);
        bus.usbResetDetect = 1'b0;
        step("t6_still_idle", S_IDLE, 0, 0, 0, 0);
        bus.txSending = 1'b0;
        step("t6_fall_quiet", S_IDLE, 0, 0, 0, 0);

        // bus reset suppresses a grant, and drops outEN from TX_START
        bus.txReq = 1'b1;
        bus.usbResetDetect = 1'b1;
        step("t7_suppress", S_IDLE, 0, 0, 0, 0);
        bus.usbResetDetect = 1'b0;
        step("t7_grant", S_TXS, 1, 1, 1, 0);
        bus.txReq = 1'b0;
        bus.usbResetDetect = 1'b1;
        step("t7_txs_rst", S_IDLE, 0, 0, 0, 0);
        bus.usbResetDetect = 1'b0;

        // illegal encoding recovers to IDLE
        @(negedge clk48);
        force dut.st = 3'd7;
        @(posedge clk48);
        #1;
        release dut.st;
        step("t8_illegal", S_IDLE, 0, 0, 0, 0);

        // RST mid-transmission and during WAIT_RESP at count 50
        bus.txReq = 1'b1;
        step("t9_grant", S_TXS, 1, 1, 1, 0);
        bus.txReq = 1'b0;
        bus.txSending = 1'b1;
        step("t9_tx", S_TX, 1, 0, 0, 0);
        RST = 1'b1;
        step("t9_rst_tx", S_IDLE, 0, 0, 0, 0);
        RST = 1'b0;
        bus.txSending = 1'b0;
        step("t9_idle", S_IDLE, 0, 0, 0, 0);
        send_pkt("t10", 1'b1, 20, S_WR);
        snap = to_cnt;
        repeat (50) tick();
        RST = 1'b1;
        step("t10_rst_wait", S_IDLE, 0, 0, 0, 0);
        RST = 1'b0;
        repeat (30) tick();
        step("t10_quiet", S_IDLE, 0, 0, 0, 0);
        chk_int("t10_no_timeout", to_cnt, snap);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
